// File: rtl/ctrl_keys.sv
// Playback control keypad: five synchronized, debounced push-buttons drive
// saturating speed and frequency-shift codes, with auto-repeat on Up/Dn keys.
module ctrl_keys #(
    parameter int DEBOUNCE      = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iBtn_SpeedUp,
    input  logic       iBtn_SpeedDn,
    input  logic       iBtn_FreqUp,
    input  logic       iBtn_FreqDn,
    input  logic       iBtn_Center,
    output logic [2:0] oControl_Speed,
    output logic [2:0] oControl_Freq,
    output logic       oChange
);

    localparam int NB      = 5;
    localparam int NR      = 4;
    localparam int DB_W    = $clog2(DEBOUNCE + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    // Bit order: 0 SpeedUp, 1 SpeedDn, 2 FreqUp, 3 FreqDn, 4 Center
    logic [NB-1:0]    raw_s;
    logic [NB-1:0]    sync1_r;
    logic [NB-1:0]    sync2_r;
    logic [NB-1:0]    level_r;
    logic [NB-1:0]    level_d_r;
    logic [NB-1:0]    rise_s;
    logic [NB-1:0]    step_s;
    logic [DB_W-1:0]  db_cnt_r [NB];
    logic [REP_W-1:0] rep_cnt_r [NR];
    logic [NR-1:0]    rep_phase_r;
    logic [NR-1:0]    rep_pulse_s;
    logic [2:0]       spd_nxt_s;
    logic [2:0]       frq_nxt_s;

    // One saturating step of a 1..7 code; simultaneous up and down cancel.
    function automatic logic [2:0] step_code(input logic [2:0] cur, input logic up, input logic dn);
        logic [2:0] res;
        res = cur;
        case ({up, dn})
            2'b10: begin
                if (cur != 3'd7) res = cur + 3'd1;
                else             res = cur;
            end
            2'b01: begin
                if (cur != 3'd1) res = cur - 3'd1;
                else             res = cur;
            end
            default: res = cur;
        endcase
        return res;
    endfunction

    assign raw_s = {iBtn_Center, iBtn_FreqDn, iBtn_FreqUp, iBtn_SpeedDn, iBtn_SpeedUp};

    // Two-flop synchronizer for all raw buttons.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            sync1_r <= {NB{1'b0}};
            sync2_r <= {NB{1'b0}};
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a new level is accepted only after DEBOUNCE consecutive mismatching cycles.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            level_r   <= {NB{1'b0}};
            level_d_r <= {NB{1'b0}};
            for (int i = 0; i < NB; i++) db_cnt_r[i] <= {DB_W{1'b0}};
        end else begin
            level_d_r <= level_r;
            for (int i = 0; i < NB; i++) begin
                if (sync2_r[i] != level_r[i]) begin
                    if (db_cnt_r[i] == DB_W'(DEBOUNCE - 1)) begin
                        level_r[i]  <= sync2_r[i];
                        db_cnt_r[i] <= {DB_W{1'b0}};
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end
            end
        end
    end

    // Auto-repeat timers: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            rep_phase_r <= {NR{1'b0}};
            for (int i = 0; i < NR; i++) rep_cnt_r[i] <= {REP_W{1'b0}};
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (!level_r[i]) begin
                    rep_cnt_r[i]   <= {REP_W{1'b0}};
                    rep_phase_r[i] <= 1'b0;
                end else if (rep_pulse_s[i]) begin
                    rep_cnt_r[i]   <= REP_W'(1);
                    rep_phase_r[i] <= 1'b1;
                end else begin
                    rep_cnt_r[i]   <= rep_cnt_r[i] + REP_W'(1);
                    rep_phase_r[i] <= rep_phase_r[i];
                end
            end
        end
    end

    // Step pulses from debounced rising edges and repeat expiry; Center never repeats.
    always_comb begin
        rise_s      = level_r & ~level_d_r;
        rep_pulse_s = {NR{1'b0}};
        for (int i = 0; i < NR; i++) begin
            if (rep_phase_r[i]) rep_pulse_s[i] = level_r[i] & (rep_cnt_r[i] == REP_W'(REPEAT_PERIOD));
            else                rep_pulse_s[i] = level_r[i] & (rep_cnt_r[i] == REP_W'(REPEAT_DELAY));
        end
        step_s = {rise_s[4], rise_s[3:0] | rep_pulse_s};
    end

    // Next control values; Center overrides any coincident Up/Dn step.
    always_comb begin
        spd_nxt_s = oControl_Speed;
        frq_nxt_s = oControl_Freq;
        if (step_s[4]) begin
            spd_nxt_s = 3'd4;
            frq_nxt_s = 3'd4;
        end else begin
            spd_nxt_s = step_code(oControl_Speed, step_s[0], step_s[1]);
            frq_nxt_s = step_code(oControl_Freq, step_s[2], step_s[3]);
        end
    end

    // Registered outputs; oChange marks the cycle a new value first appears.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oControl_Speed <= 3'd4;
            oControl_Freq  <= 3'd4;
            oChange        <= 1'b0;
        end else begin
            oControl_Speed <= spd_nxt_s;
            oControl_Freq  <= frq_nxt_s;
            oChange        <= (spd_nxt_s != oControl_Speed) || (frq_nxt_s != oControl_Freq);
        end
    end

endmodule

// File: tb/tb_ctrl_keys.sv
// Directed bench for ctrl_keys: expected output changes are queued by the
// stimulus and checked by an independent monitor on every oChange pulse.
module tb_ctrl_keys;

    logic       iClk = 1'b0;
    logic       iReset_n;
    logic       iBtn_SpeedUp, iBtn_SpeedDn, iBtn_FreqUp, iBtn_FreqDn, iBtn_Center;
    logic [2:0] oControl_Speed, oControl_Freq;
    logic       oChange;

    typedef struct packed {
        int unsigned cyc;
        logic [2:0]  spd;
        logic [2:0]  frq;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int unsigned base;
    logic [2:0]  prev_spd = 3'd4;
    logic [2:0]  prev_frq = 3'd4;

    ctrl_keys #(.DEBOUNCE(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
        .iClk(iClk), .iReset_n(iReset_n),
        .iBtn_SpeedUp(iBtn_SpeedUp), .iBtn_SpeedDn(iBtn_SpeedDn),
        .iBtn_FreqUp(iBtn_FreqUp), .iBtn_FreqDn(iBtn_FreqDn),
        .iBtn_Center(iBtn_Center),
        .oControl_Speed(oControl_Speed), .oControl_Freq(oControl_Freq),
        .oChange(oChange)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic push(input int s, input int f, input int unsigned at);
        exp_q.push_back('{cyc: at, spd: 3'(s), frq: 3'(f)});
    endtask

    // Monitor: every oChange pulse must match the next queued expectation.
    always @(negedge iClk) begin
        exp_t e;
        if (iReset_n === 1'b1) begin
            if (oChange) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change: speed %0d freq %0d at cycle %0d, none expected",
                             oControl_Speed, oControl_Freq, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (oControl_Speed == e.spd && oControl_Freq == e.frq && cyc == e.cyc) n_pass++;
                    else $display("FAIL change_event: got speed %0d freq %0d cycle %0d, expected speed %0d freq %0d cycle %0d",
                                  oControl_Speed, oControl_Freq, cyc, e.spd, e.frq, e.cyc);
                end
            end else if (oControl_Speed != prev_spd || oControl_Freq != prev_frq) begin
                n_total++;
                $display("FAIL silent_change: speed %0d->%0d freq %0d->%0d at cycle %0d without oChange",
                         prev_spd, oControl_Speed, prev_frq, oControl_Freq, cyc);
            end
        end
        prev_spd = oControl_Speed;
        prev_frq = oControl_Freq;
    end

    initial begin
        iReset_n = 1'b0;
        {iBtn_SpeedUp, iBtn_SpeedDn, iBtn_FreqUp, iBtn_FreqDn, iBtn_Center} = 5'b00000;
        tick(3);
        chk("reset_speed", int'(oControl_Speed), 4);
        chk("reset_freq", int'(oControl_Freq), 4);
        chk("reset_change", int'(oChange), 0);
        iReset_n = 1'b1;
        tick(3);

        // Single clean press: 4 -> 5, seven cycles after the raw edge
        iBtn_SpeedUp = 1'b1; push(5, 4, cyc + 7); tick(10);
        iBtn_SpeedUp = 1'b0; tick(20);

        // Bouncing press collapses to one increment
        for (int i = 0; i < 5; i++) begin
            iBtn_SpeedUp = 1'b1; tick(2);
            iBtn_SpeedUp = 1'b0; tick(2);
        end
        iBtn_SpeedUp = 1'b1; push(6, 4, cyc + 7); tick(10);
        iBtn_SpeedUp = 1'b0; tick(20);
        chk("bounce_speed", int'(oControl_Speed), 6);

        // FreqDn auto-repeat down to saturation
        iBtn_FreqDn = 1'b1; base = cyc;
        push(6, 3, base + 7); push(6, 2, base + 27); push(6, 1, base + 35);
        tick(100);
        iBtn_FreqDn = 1'b0; tick(20);
        chk("freq_sat_low", int'(oControl_Freq), 1);

        // Up and Dn together cancel
        iBtn_SpeedUp = 1'b1; iBtn_SpeedDn = 1'b1; tick(10);
        iBtn_SpeedUp = 1'b0; iBtn_SpeedDn = 1'b0; tick(20);
        chk("updn_cancel", int'(oControl_Speed), 6);

        // Independent pairs stepping together: Speed 7, Freq 2
        iBtn_SpeedUp = 1'b1; iBtn_FreqUp = 1'b1; push(7, 2, cyc + 7); tick(10);
        iBtn_SpeedUp = 1'b0; iBtn_FreqUp = 1'b0; tick(20);

        // Center beats a coincident FreqUp
        iBtn_Center = 1'b1; iBtn_FreqUp = 1'b1; push(4, 4, cyc + 7); tick(10);
        iBtn_Center = 1'b0; iBtn_FreqUp = 1'b0; tick(20);

        // Center at defaults: no pulse
        iBtn_Center = 1'b1; tick(10);
        iBtn_Center = 1'b0; tick(20);
        chk("center_idle_speed", int'(oControl_Speed), 4);
        chk("center_idle_freq", int'(oControl_Freq), 4);

        // SpeedDn repeat to saturation at 1
        iBtn_SpeedDn = 1'b1; base = cyc;
        push(3, 4, base + 7); push(2, 4, base + 27); push(1, 4, base + 35);
        tick(60);
        iBtn_SpeedDn = 1'b0; tick(20);
        chk("speed_sat_low", int'(oControl_Speed), 1);

        // Reset mid-repeat while held, then one fresh step after release
        iBtn_SpeedUp = 1'b1; base = cyc;
        push(2, 4, base + 7); push(3, 4, base + 27);
        tick(30);
        iReset_n = 1'b0; #1;
        chk("midrep_reset_speed", int'(oControl_Speed), 4);
        chk("midrep_reset_freq", int'(oControl_Freq), 4);
        chk("midrep_reset_change", int'(oChange), 0);
        tick(1);
        iReset_n = 1'b1; push(5, 4, cyc + 7); tick(10);
        iBtn_SpeedUp = 1'b0; tick(20);
        chk("final_speed", int'(oControl_Speed), 5);
        chk("pending_events", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ctrl_keys.md
CTRL_KEYS -- requirements
Module: ctrl_keys

Interface
REQ-001 DEBOUNCE, default 1_000_000, clock cycles a synchronized button must hold a new level before it is accepted.
REQ-002 REPEAT_DELAY, default 50_000_000, cycles a debounced press must be held before auto-repeat starts.
REQ-003 REPEAT_PERIOD, default 10_000_000, cycles between auto-repeat steps.
REQ-004 iClk  input  1  system clock; all state SHALL be on its rising edge.
REQ-005 iReset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 iBtn_SpeedUp, iBtn_SpeedDn, iBtn_FreqUp, iBtn_FreqDn  input  1 each  raw asynchronous push-buttons, active high.
REQ-007 iBtn_Center  input  1  raw asynchronous push-button, active high; restores defaults.
REQ-008 oControl_Speed  output  3  speed code for the display/player: 1=0.25, 2=0.50, 3=0.75, 4=1.00, 5=1.50, 6=2.00, 7=3.00.
REQ-009 oControl_Freq  output  3  frequency shift code: 1=-3, 2=-2, 3=-1, 4=0, 5=+1, 6=+2, 7=+3.
REQ-010 oChange  output  1  one-cycle pulse when either control output changes value.

Function
REQ-011 Each of the five buttons SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per button, a debounced level SHALL take the synchronized value only after that value has differed from the current debounced level for DEBOUNCE consecutive cycles; any intermediate match restarts the count.
REQ-013 A debounced 0->1 transition SHALL produce a one-cycle step pulse; 1->0 produces nothing.
REQ-014 Auto-repeat: while an Up/Dn debounced level stays 1, an extra step pulse SHALL occur REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles; the repeat counter clears when the level drops to 0.
REQ-015 iBtn_Center SHALL NOT auto-repeat.
REQ-016 Outputs SHALL be registered and update on the cycle after the step pulse; raw edge to output change = DEBOUNCE+3 cycles.
REQ-017 Speed Up step: oControl_Speed+1, saturating at 7; Speed Dn step: -1, saturating at 1.
REQ-018 Freq Up/Dn steps SHALL behave identically on oControl_Freq, range 1..7.
REQ-019 Code 0 SHALL never be output on either control.
REQ-020 Up and Dn step pulses of the same pair in the same cycle SHALL leave that output unchanged.
REQ-021 A Center step pulse SHALL set both outputs to 4 and override any coincident Up/Dn pulse.
REQ-022 Speed and Freq pairs SHALL be independent; simultaneous steps on both pairs are both applied.
REQ-023 oChange SHALL be 1 for exactly the cycle in which the new value first appears, and only if at least one output value differs from the previous cycle; steps at saturation and Center at defaults produce no pulse.

Reset
REQ-024 On iReset_n=0, asynchronously: oControl_Speed=4, oControl_Freq=4, oChange=0, and all synchronizer, debounce, level and repeat state cleared to 0.
REQ-025 Release of reset while a button is held SHALL register a press once debounced, i.e. one step DEBOUNCE+3 cycles after release.
REQ-026 Reset asserted mid-debounce or mid-repeat SHALL abandon that operation with no step applied.

Verification (DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-027 Reset then SpeedUp held 10 cycles -> Speed 4->5 exactly 7 cycles after the raw edge, one oChange pulse, Freq stays 4.
REQ-028 SpeedUp bouncing 1/0 every 2 cycles for 20 cycles, then steady 1 -> exactly one increment.
REQ-029 FreqDn held 100 cycles from 4 -> 3, 2, 1 at first step, +20 and +28 cycles; later repeats leave it at 1 with no oChange.
REQ-030 SpeedUp and SpeedDn pressed in the same cycle -> Speed unchanged, no oChange.
REQ-031 Speed=7, Freq=2, press Center together with FreqUp -> both outputs 4, single oChange pulse.
REQ-032 Assert iReset_n=0 for 1 cycle while SpeedUp held mid-repeat -> outputs 4 immediately; after release, one step 7 cycles later.
